// File: rtl/adder_pkg.sv
// Shared helpers for the adder feeder: counter/pointer widths and the operand-slot index type.
package adder_pkg;

    localparam int SLOT_W = 8;
    typedef logic [SLOT_W-1:0] slot_idx_t;

    function automatic int credit_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/adder_feeder_fifo.sv
// Result FIFO: DEPTH x BITS, registered storage, head presented combinationally.
module adder_feeder_fifo
    import adder_pkg::*;
#(
    parameter int BITS  = 8,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push_i,
    input  logic [BITS-1:0] data_i,
    input  logic            pop_i,
    output logic            empty_o,
    output logic            full_o,
    output logic [BITS-1:0] head_o
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = credit_w(DEPTH);

    logic [BITS-1:0] mem_q [DEPTH];
    logic [PW-1:0]   wr_q, rd_q;
    logic [CW-1:0]   cnt_q;

    // Storage is cleared on reset so the head reads zero while empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_q] <= data_i;
                wr_q        <= wr_q + 1'b1;
            end
            if (pop_i) rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
        end
    end

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign head_o  = mem_q[rd_q];

endmodule

// File: rtl/adder_feeder.sv
// Packs NUM operand beats into one adder-tree issue and buffers the returned sums,
// using credits so the non-backpressurable tree can never overflow the result FIFO.
module adder_feeder
    import adder_pkg::*;
#(
    parameter int BITS  = 8,
    parameter int NUM   = 4,
    parameter int DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic [BITS-1:0]     in_data,
    input  logic                in_last,
    output logic                in_ready,
    output logic                add_valid,
    output logic [NUM*BITS-1:0] add_ops,
    input  logic                res_valid,
    input  logic [BITS-1:0]     res_data,
    output logic                o_valid,
    output logic [BITS-1:0]     o_data,
    input  logic                o_ready,
    output logic                err
);

    localparam int CW = credit_w(DEPTH);

    slot_idx_t           cnt_q, cnt_d;
    logic [NUM*BITS-1:0] buf_q, buf_d, ops_q, ops_d, beat_vec;
    logic                issue_q;
    logic [CW-1:0]       used_q, used_d, infl_q, infl_d;
    logic                err_q, err_d;
    logic                accept, complete, pop, push, fifo_empty, fifo_full;

    // used counts both groups still in the tree and sums waiting in the FIFO.
    assign in_ready = (used_q != CW'(DEPTH));
    assign accept   = in_valid & in_ready;
    assign complete = accept & ((cnt_q == slot_idx_t'(NUM - 1)) | in_last);
    assign pop      = o_valid & o_ready;
    assign push     = res_valid & (infl_q != '0) & (~fifo_full | pop);

    always_comb begin
        beat_vec = '0;
        for (int k = 0; k < NUM; k++)
            if (cnt_q == slot_idx_t'(k)) beat_vec[k*BITS +: BITS] = in_data;
        cnt_d = cnt_q;
        buf_d = buf_q;
        ops_d = ops_q;
        if (accept) begin
            if (complete) begin
                // Slots above the closing beat are still zero from the last clear.
                cnt_d = '0;
                buf_d = '0;
                ops_d = buf_q | beat_vec;
            end else begin
                cnt_d = cnt_q + 1'b1;
                buf_d = buf_q | beat_vec;
            end
        end
        used_d = used_q + CW'(complete) - CW'(pop);
        infl_d = infl_q + CW'(issue_q) - CW'(push);
        err_d  = err_q | (res_valid & (infl_q == '0));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            buf_q   <= '0;
            ops_q   <= '0;
            issue_q <= 1'b0;
            used_q  <= '0;
            infl_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            ops_q   <= ops_d;
            issue_q <= complete;
            used_q  <= used_d;
            infl_q  <= infl_d;
            err_q   <= err_d;
        end
    end

    adder_feeder_fifo #(.BITS(BITS), .DEPTH(DEPTH)) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push_i (push),
        .data_i (res_data),
        .pop_i  (pop),
        .empty_o(fifo_empty),
        .full_o (fifo_full),
        .head_o (o_data)
    );

    assign add_valid = issue_q;
    assign add_ops   = ops_q;
    assign o_valid   = ~fifo_empty;
    assign err       = err_q;

endmodule

// File: tb/tb_adder_feeder.sv
// Bench for adder_feeder: 2-cycle adder tree model, beat-level scoreboard, directed and random phases.
module tb_adder_feeder;

    localparam int BITS = 8, NUM = 4, DEPTH = 4;

    logic                clk = 1'b0, rst_n = 1'b0;
    logic                in_valid, in_last, in_ready, add_valid, res_valid, o_valid, o_ready, err;
    logic [BITS-1:0]     in_data, res_data, o_data;
    logic [NUM*BITS-1:0] add_ops;

    adder_feeder #(.BITS(BITS), .NUM(NUM), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(in_ready), .add_valid(add_valid), .add_ops(add_ops), .res_valid(res_valid),
        .res_data(res_data), .o_valid(o_valid), .o_data(o_data), .o_ready(o_ready), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Adder tree model: fixed 2-cycle latency, sum truncated to BITS.
    logic            p0v, p1v, spur_v;
    logic [BITS-1:0] p0d, p1d, spur_d;

    function automatic logic [BITS-1:0] tree_sum(input logic [NUM*BITS-1:0] v);
        logic [BITS-1:0] s;
        s = '0;
        for (int k = 0; k < NUM; k++) s = s + v[k*BITS +: BITS];
        return s;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p0v <= 1'b0; p1v <= 1'b0; p0d <= '0; p1d <= '0;
        end else begin
            p0v <= add_valid; p0d <= tree_sum(add_ops);
            p1v <= p0v;       p1d <= p0d;
        end
    end

    assign res_valid = p1v | spur_v;
    assign res_data  = p1v ? p1d : spur_d;

    // Scoreboard: groups are formed from accepted beats; sums must return in issue order.
    logic [NUM*BITS-1:0] exp_ops_q [$];
    logic [BITS-1:0]     exp_sum_q [$];
    logic [NUM*BITS-1:0] cur_ops;
    logic [BITS-1:0]     cur_sum;
    int                  cur_n, model_used;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_ops_q.delete(); exp_sum_q.delete();
            cur_ops = '0; cur_sum = '0; cur_n = 0; model_used = 0;
        end else begin
            if (add_valid) begin
                chk("issue_pending", exp_ops_q.size() != 0, 1);
                if (exp_ops_q.size() != 0) chk("sb_add_ops", add_ops, exp_ops_q.pop_front());
            end
            if (o_valid && o_ready) begin
                chk("sum_pending", exp_sum_q.size() != 0, 1);
                if (exp_sum_q.size() != 0) chk("sb_o_data", o_data, exp_sum_q.pop_front());
            end
            chk("sb_in_ready", in_ready, model_used != DEPTH);
            chk("sb_used_bound", model_used <= DEPTH, 1);
            if (in_valid && in_ready) begin
                cur_ops[cur_n*BITS +: BITS] = in_data;
                cur_sum = cur_sum + in_data;
                cur_n++;
                if (cur_n == NUM || in_last) begin
                    exp_ops_q.push_back(cur_ops);
                    exp_sum_q.push_back(cur_sum);
                    model_used++;
                    cur_ops = '0; cur_sum = '0; cur_n = 0;
                end
            end
            if (o_valid && o_ready) model_used--;
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic send_beat(input logic [BITS-1:0] d, input logic last);
        int c;
        c = 0;
        in_valid = 1'b1; in_data = d; in_last = last;
        while (!in_ready && c < 200) begin step(); c++; end
        chk("beat_ready_wait", in_ready, 1);
        step();
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic wait_ovalid(input int maxc);
        int c;
        c = 0;
        while (!o_valid && c < maxc) begin step(); c++; end
        chk("o_valid_wait", o_valid, 1);
    endtask

    task automatic drain();
        int c;
        c = 0;
        o_ready = 1'b1;
        while ((exp_sum_q.size() != 0 || o_valid) && c < 300) begin step(); c++; end
        chk("drain_queue", exp_sum_q.size(), 0);
        chk("drain_o_valid", o_valid, 0);
        o_ready = 1'b0;
    endtask

    typedef struct {
        logic [NUM-1:0][BITS-1:0] d;
        int                       n;
        logic                     last;
        logic [NUM*BITS-1:0]      ops;
        logic [BITS-1:0]          sum;
    } vec_t;

    vec_t vt [5];

    initial begin
        vt[0] = '{d: 32'h04030201, n: 4, last: 1'b0, ops: 32'h04030201, sum: 8'h0A};
        vt[1] = '{d: 32'hEEEE0605, n: 2, last: 1'b1, ops: 32'h00000605, sum: 8'h0B};
        vt[2] = '{d: 32'h000064C8, n: 4, last: 1'b0, ops: 32'h000064C8, sum: 8'h2C};
        vt[3] = '{d: 32'hAAAAAA7F, n: 1, last: 1'b1, ops: 32'h0000007F, sum: 8'h7F};
        vt[4] = '{d: 32'hFFFFFFFF, n: 4, last: 1'b0, ops: 32'hFFFFFFFF, sum: 8'hFC};

        in_valid = 0; in_data = 0; in_last = 0; o_ready = 0; spur_v = 0; spur_d = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_add_valid", add_valid, 0);
        chk("rst_add_ops", add_ops, 0);
        chk("rst_o_valid", o_valid, 0);
        chk("rst_o_data", o_data, 0);
        chk("rst_err", err, 0);
        step();

        for (int t = 0; t < 5; t++) begin
            for (int b = 0; b < vt[t].n; b++) begin
                in_valid = 1'b1; in_data = vt[t].d[b]; in_last = vt[t].last && (b == vt[t].n - 1);
                step();
            end
            in_valid = 1'b0; in_last = 1'b0;
            chk("dir_add_valid", add_valid, 1);
            chk("dir_add_ops", add_ops, vt[t].ops);
            step();
            chk("dir_pulse_end", add_valid, 0);
            chk("dir_ops_hold", add_ops, vt[t].ops);
            wait_ovalid(40);
            chk("dir_sum", o_data, vt[t].sum);
            o_ready = 1'b1; step(); o_ready = 1'b0;
            chk("dir_popped", o_valid, 0);
            chk("dir_err", err, 0);
        end

        // Backpressure: DEPTH full groups with no pops exhaust the credits.
        for (int i = 0; i < 4 * NUM; i++) send_beat(8'($urandom), 1'b0);
        chk("bp_ready_low", in_ready, 0);
        in_valid = 1'b1; in_data = 8'h33; in_last = 1'b1;
        repeat (8) step();
        chk("bp_held", in_ready, 0);
        chk("bp_fifo_valid", o_valid, 1);
        o_ready = 1'b1; step(); o_ready = 1'b0;
        chk("bp_ready_back", in_ready, 1);
        step();
        in_valid = 1'b0; in_last = 1'b0;
        chk("bp_17_issue", add_valid, 1);
        chk("bp_17_ops", add_ops, 32'h00000033);
        drain();

        // Random traffic with random consumer stalls and early group closes.
        for (int i = 0; i < 600; i++) begin
            in_valid = ($urandom_range(3) != 0);
            in_data  = 8'($urandom);
            in_last  = ($urandom_range(5) == 0);
            o_ready  = ($urandom_range(3) != 0);
            step();
        end
        in_valid = 1'b0; in_last = 1'b0;
        if (cur_n != 0) send_beat(8'($urandom), 1'b1);
        drain();
        chk("rand_err", err, 0);

        // Mid-group reset discards the partial group; a later result is spurious.
        send_beat(8'h11, 1'b0);
        send_beat(8'h22, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_add_valid", add_valid, 0);
        chk("mid_rst_add_ops", add_ops, 0);
        chk("mid_rst_o_valid", o_valid, 0);
        chk("mid_rst_o_data", o_data, 0);
        step(); step();
        rst_n = 1'b1;
        repeat (5) step();
        chk("post_rst_add_valid", add_valid, 0);
        chk("post_rst_err", err, 0);
        spur_v = 1'b1; spur_d = 8'h55;
        step();
        spur_v = 1'b0;
        chk("spur_err", err, 1);
        repeat (5) step();
        chk("spur_err_sticky", err, 1);
        chk("spur_o_valid", o_valid, 0);
        chk("spur_in_ready", in_ready, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
